// File: rtl/gol_pkg.sv
// Shared constants and types for the Game of Life board dump path.
package gol_pkg;

  localparam int unsigned GOL_ROWS = 8;
  localparam int unsigned GOL_COLS = 8;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROW_BITS = 2'd1,
    ROW_NL   = 2'd2,
    FRAME_NL = 2'd3
  } ser_state_e;

endpackage

// File: rtl/gol_frame_serializer.sv
// Captures one board generation on a strobe and streams it as ASCII rows of
// '0'/'1' characters, each row ended by LF, with an extra LF closing the frame.
module gol_frame_serializer
  import gol_pkg::*;
#(
  parameter int unsigned ROWS       = GOL_ROWS,
  parameter int unsigned COLS       = GOL_COLS,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS*COLS-1:0]   state_i,
  input  logic                   state_valid_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned IDX_W = $clog2(CELLS);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  ser_state_e             state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [CELLS-1:0]       shadow_q, shadow_d;
  logic                   done_q, done_d;
  logic [DROP_CNT_W-1:0]  drop_q;
  logic                   drop_inc;
  logic                   accept;
  logic [IDX_W-1:0]       cell_idx;

  // Outputs decode only registered state, so ready never reaches valid.
  assign tx_valid_o   = (state_q != IDLE);
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;
  assign drop_cnt_o   = drop_q;
  assign accept       = tx_valid_o & tx_ready_i;

  // Row 0 sits in the top COLS bits with column 0 at its MSB.
  assign cell_idx = IDX_W'(CELLS - 1) - (IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q));

  always_comb begin
    tx_data_o = '0;
    case (state_q)
      ROW_BITS: tx_data_o = shadow_q[cell_idx] ? ASCII_ONE : ASCII_ZERO;
      ROW_NL,
      FRAME_NL: tx_data_o = ASCII_LF;
      default:  tx_data_o = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (state_valid_i) begin
          shadow_d = state_i;
          row_d    = '0;
          col_d    = '0;
          state_d  = ROW_BITS;
        end
      end
      ROW_BITS: begin
        drop_inc = state_valid_i;
        if (accept) begin
          if (col_q == COL_LAST) state_d = ROW_NL;
          else                   col_d   = col_q + COL_W'(1);
        end
      end
      ROW_NL: begin
        drop_inc = state_valid_i;
        if (accept) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = FRAME_NL;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = ROW_BITS;
          end
        end
      end
      FRAME_NL: begin
        // The closing-LF accept cycle may chain straight into the next frame.
        drop_inc = state_valid_i & ~accept;
        if (accept) begin
          done_d = 1'b1;
          if (state_valid_i) begin
            shadow_d = state_i;
            row_d    = '0;
            col_d    = '0;
            state_d  = ROW_BITS;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

endmodule
